// File: rtl/spwm_pkg.sv
// Shared definitions for the three-phase sinusoidal PWM modulator.
//   - Default values for DATA_W, CARRIER_MAX and DEAD_CYCLES
//   - Per-phase gate FSM state type
//   - Phase index constants (A/B/C) used for the gate bit ordering
package spwm_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int CARRIER_MAX_DEF = 254;
  localparam int DEAD_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_DEAD = 2'd1,
    ST_HI   = 2'd2,
    ST_LO   = 2'd3
  } phase_state_e;

  localparam int PH_A = 0;
  localparam int PH_B = 1;
  localparam int PH_C = 2;

endpackage

// File: rtl/spwm_deadtime.sv
// Single-phase gate generator: turns the raw carrier-compare bit of one
// phase into complementary high/low-side gate signals.
//
// Build option SPWM_DEADTIME_EN:
//   defined   - OFF/DEAD/HI/LO state machine; every change of the raw
//               compare passes through DEAD_CYCLES clocks with both gates
//               low, and pulses shorter than that are swallowed.
//   undefined - gates are the registered compare bit and its complement
//               (one clock latency), both low while disabled.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   enable   in   low forces both gates off on the next edge
//   raw      in   carrier compare result for this phase
//   gate_hi  out  high-side gate (registered)
//   gate_lo  out  low-side gate (registered)
module spwm_deadtime
  import spwm_pkg::*;
#(
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic raw,
  output logic gate_hi,
  output logic gate_lo
);

  if (DEAD_CYCLES < 1) begin : g_bad_dead
    $error("spwm_deadtime: DEAD_CYCLES must be >= 1");
  end

`ifdef SPWM_DEADTIME_EN

  localparam int CNT_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEAD_CYCLES - 1);

  phase_state_e     state_p1, state_nxt;
  logic             target_p1, target_nxt;
  logic [CNT_W-1:0] cnt_p1, cnt_nxt;

  always_comb begin
    state_nxt  = state_p1;
    target_nxt = target_p1;
    cnt_nxt    = cnt_p1;
    case (state_p1)
      ST_OFF: begin
        if (enable) begin
          state_nxt  = ST_DEAD;
          target_nxt = raw;
          cnt_nxt    = '0;
        end
      end
      ST_DEAD: begin
        // A compare change inside the dead window restarts it, which is
        // what suppresses runt pulses.
        if (raw != target_p1) begin
          target_nxt = raw;
          cnt_nxt    = '0;
        end else if (cnt_p1 == CNT_LAST) begin
          state_nxt = target_p1 ? ST_HI : ST_LO;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_p1 + 1'b1;
        end
      end
      ST_HI: begin
        if (!raw) begin
          state_nxt  = ST_DEAD;
          target_nxt = 1'b0;
          cnt_nxt    = '0;
        end
      end
      ST_LO: begin
        if (raw) begin
          state_nxt  = ST_DEAD;
          target_nxt = 1'b1;
          cnt_nxt    = '0;
        end
      end
      default: state_nxt = ST_OFF;
    endcase
    if (!enable) begin
      state_nxt = ST_OFF;
    end
  end

  // ---- stage p1: state register and gate decode ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1  <= ST_OFF;
      target_p1 <= 1'b0;
      cnt_p1    <= '0;
      gate_hi   <= 1'b0;
      gate_lo   <= 1'b0;
    end else begin
      state_p1  <= state_nxt;
      target_p1 <= target_nxt;
      cnt_p1    <= cnt_nxt;
      gate_hi   <= (state_nxt == ST_HI);
      gate_lo   <= (state_nxt == ST_LO);
    end
  end

`else

  // ---- stage p1: registered compare, complementary gates ----
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_hi <= 1'b0;
      gate_lo <= 1'b0;
    end else begin
      gate_hi <= enable & raw;
      gate_lo <= enable & ~raw;
    end
  end

`endif

endmodule

// File: rtl/spwm_three_phase.sv
// Three-phase sinusoidal PWM modulator. Compares three modulating waves
// against a shared symmetric triangle carrier and drives complementary
// gate pairs for a three-phase bridge through per-phase gate generators.
// Modulating samples are latched at the carrier valley so mid-period
// input changes cannot disturb the gates.
//
// Build option SPWM_DEADTIME_EN: enables dead-time insertion in
// spwm_deadtime; without it the gates are plain complementary PWM.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   enable       in   run modulator; low holds carrier at 0, gates off
//   mod_a/b/c    in   unsigned modulating samples (DATA_W)
//   gate_hi[2:0] out  high-side gates, [0]=A [1]=B [2]=C
//   gate_lo[2:0] out  low-side gates, same ordering
//   carrier      out  current triangle value
//   period_tick  out  high while enabled and carrier is at the valley
module spwm_three_phase
  import spwm_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int CARRIER_MAX = CARRIER_MAX_DEF,
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] mod_a,
  input  logic [DATA_W-1:0] mod_b,
  input  logic [DATA_W-1:0] mod_c,
  output logic [2:0]        gate_hi,
  output logic [2:0]        gate_lo,
  output logic [DATA_W-1:0] carrier,
  output logic              period_tick
);

  localparam logic [DATA_W-1:0] TOP_M1 = DATA_W'(CARRIER_MAX - 1);

  function automatic logic above_carrier(input logic [DATA_W-1:0] level,
                                         input logic [DATA_W-1:0] carr);
    return level > carr;
  endfunction

  logic [DATA_W-1:0] carrier_p0;
  logic              dir_up_p0;
  logic [DATA_W-1:0] mod_in [3];
  logic [DATA_W-1:0] shadow_p0 [3];
  logic [2:0]        raw_p0;
  logic              valley_p0;

  assign mod_in[PH_A] = mod_a;
  assign mod_in[PH_B] = mod_b;
  assign mod_in[PH_C] = mod_c;

  assign valley_p0 = (carrier_p0 == '0);

  // ---- stage p0: carrier counter and valley-latched shadows ----
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      carrier_p0 <= '0;
      dir_up_p0  <= 1'b1;
    end else if (dir_up_p0) begin
      carrier_p0 <= carrier_p0 + 1'b1;
      if (carrier_p0 == TOP_M1) begin
        dir_up_p0 <= 1'b0;
      end
    end else begin
      carrier_p0 <= carrier_p0 - 1'b1;
      if (carrier_p0 == DATA_W'(1)) begin
        dir_up_p0 <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        shadow_p0[i] <= '0;
      end else if (valley_p0 || !enable) begin
        shadow_p0[i] <= mod_in[i];
      end
    end
  end

  always_comb begin
    raw_p0 = '0;
    for (int i = 0; i < 3; i++) begin
      raw_p0[i] = above_carrier(shadow_p0[i], carrier_p0);
    end
  end

  // ---- stage p1: per-phase gate generation ----
  for (genvar g = 0; g < 3; g++) begin : g_phase
    spwm_deadtime #(
      .DEAD_CYCLES(DEAD_CYCLES)
    ) u_dt (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .raw     (raw_p0[g]),
      .gate_hi (gate_hi[g]),
      .gate_lo (gate_lo[g])
    );
  end

  assign carrier     = carrier_p0;
  assign period_tick = !rst && enable && valley_p0;

endmodule
